// File: rtl/fp_pkg.sv
// Shared helpers for the floating-point datapath blocks:
// exponent constants, operand classification and the canonical quiet NaN.
package fp_pkg;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Canonical qNaN {0, all-ones, 1, zeros}; callers truncate to their word width.
  function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
    logic [63:0] ones;
    ones = (64'd1 << exp_w) - 64'd1;
    return (ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

  // Subnormal operands (exp == 0) are treated as zero.
  function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                         input logic frac_zero);
    if (exp_zero) return ZERO;
    if (!exp_ones) return NORM;
    return frac_zero ? INF : NAN;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational normalise + round-to-nearest-even of a (MAN_W+1)x(MAN_W+1) significand
// product, with the matching exponent adjustment. Shared with the FP adder.
module fp_round_rne #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [2*MAN_W+1:0]      prod,
  input  logic signed [EXP_W+1:0] exp_in,
  output logic [MAN_W-1:0]        frac,
  output logic signed [EXP_W+1:0] exp_out
);

  localparam int PW = 2*MAN_W + 2;
  localparam int XW = EXP_W + 2;

  // Fraction bits below the leading one, left-aligned to bit PW-2.
  logic [PW-2:0]          norm;
  logic signed [XW-1:0]   exp_n;
  logic                   lsb;
  logic                   guard;
  logic                   sticky;
  logic                   round_up;
  logic                   carry;

  always_comb begin
    if (prod[PW-1]) begin
      norm  = prod[PW-2:0];
      exp_n = exp_in + XW'(1);
    end else begin
      norm  = {prod[PW-3:0], 1'b0};
      exp_n = exp_in;
    end
    lsb      = norm[MAN_W+1];
    guard    = norm[MAN_W];
    sticky   = |norm[MAN_W-1:0];
    round_up = guard & (sticky | lsb);
    // An all-ones fraction rounding up wraps to zero and bumps the exponent.
    {carry, frac} = {1'b0, norm[PW-2:MAN_W+1]} + {{MAN_W{1'b0}}, round_up};
    exp_out = exp_n + $signed({{(XW-1){1'b0}}, carry});
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready on both sides,
// RNE rounding, DAZ/FTZ and registered overflow/underflow/exception flags.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     exception
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2*MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS_X    = XW'(bias(EXP_W));
  localparam logic signed [XW-1:0] EXP_MAX_X = XW'(exp_max(EXP_W));
  localparam logic [W-1:0]         QNAN      = W'(qnan_bits(EXP_W, MAN_W));

  logic en;

  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  fp_class_e          ca, cb, cls_d;
  logic signed [XW-1:0] exp_sum;
  logic [PW-1:0]      prod;

  logic               s1_valid, s1_sign;
  fp_class_e          s1_cls;
  logic signed [XW-1:0] s1_exp;
  logic [PW-1:0]      s1_prod;

  logic [MAN_W-1:0]   frac_r;
  logic signed [XW-1:0] exp_r;

  logic               s2_valid, s2_sign;
  fp_class_e          s2_cls;
  logic signed [XW-1:0] s2_exp;
  logic [MAN_W-1:0]   s2_frac;

  logic [W-1:0]       res_d;
  logic               ovf_d, unf_d, exc_d;

  // Whole pipe advances together; bubbles are not squeezed out.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign ca = classify(ea == '0, &ea, fa == '0);
  assign cb = classify(eb == '0, &eb, fb == '0);

  always_comb begin
    cls_d = NORM;
    if (ca == NAN || cb == NAN || (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF))
      cls_d = NAN;
    else if (ca == INF || cb == INF)
      cls_d = INF;
    else if (ca == ZERO || cb == ZERO)
      cls_d = ZERO;
  end

  // Widened by two bits so the biased sum cannot wrap for any normal operands.
  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_X;
  assign prod    = {{(MAN_W+1){1'b0}}, 1'b1, fa} * {{(MAN_W+1){1'b0}}, 1'b1, fb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= ZERO;
      s1_exp   <= '0;
      s1_prod  <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sign  <= sa ^ sb;
      s1_cls   <= cls_d;
      s1_exp   <= exp_sum;
      s1_prod  <= prod;
    end
  end

  fp_round_rne #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .prod    (s1_prod),
    .exp_in  (s1_exp),
    .frac    (frac_r),
    .exp_out (exp_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_cls   <= ZERO;
      s2_exp   <= '0;
      s2_frac  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_cls   <= s1_cls;
      s2_exp   <= exp_r;
      s2_frac  <= frac_r;
    end
  end

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    exc_d = 1'b0;
    case (s2_cls)
      NAN: begin
        res_d = QNAN;
        exc_d = 1'b1;
      end
      INF:  res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ZERO: res_d = {s2_sign, {(W-1){1'b0}}};
      default: begin
        if (s2_exp >= EXP_MAX_X) begin
          res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d = 1'b1;
        end else if (s2_exp[XW-1] || s2_exp == '0) begin
          res_d = {s2_sign, {(W-1){1'b0}}};
          unf_d = 1'b1;
        end else begin
          res_d = {s2_sign, s2_exp[EXP_W-1:0], s2_frac};
        end
      end
    endcase
  end

  // Outputs and flags read as zero whenever no result is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      exception <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      result    <= s2_valid ? res_d : '0;
      overflow  <= s2_valid & ovf_d;
      underflow <= s2_valid & unf_d;
      exception <= s2_valid & exc_d;
    end
  end

endmodule
